// File: rtl/pda_display_pkg.sv
// Shared seven-segment types and the hex glyph table for the PDA display path.
package pda_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b0000000;

  // Segment order is a..g from bit 6 down to bit 0, active-high.
  localparam seg7_t SEG_HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment glyph decoder.
module hex_to_seg7
  import pda_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  always_comb begin
    seg_o = SEG_HEX[nibble_i];
  end

endmodule

// File: rtl/pixel_display_scanner.sv
// Double-buffered, time-multiplexed hex seven-segment scanner.
// Optional leading-zero blanking when PDA_DISP_BLANK_EN is defined.
module pixel_display_scanner
  import pda_display_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1024
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              hold,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_sel,
  output logic [DATA_W-1:0] shown,
  output logic              frame
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [DATA_W-1:0] shown_q, shown_d;
  logic              frame_q, frame_d;
  seg7_t             seg_q, seg_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;

  logic              tick;
  logic              boundary;
  logic [3:0]        nibble;
  seg7_t             seg_hex;

  always_comb begin
    tick     = !hold && (pcnt_q == PW'(SCAN_DIV - 1));
    boundary = tick && (idx_q == IW'(DIGITS - 1));
  end

  always_comb begin
    pcnt_d   = pcnt_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    shown_d  = shown_q;
    frame_d  = boundary;

    if (!hold) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end

    if (load) begin
      pend_d   = data;
      pend_v_d = 1'b1;
    end

    // A load landing on the boundary bypasses the pending slot entirely.
    if (boundary) begin
      pend_v_d = 1'b0;
      if (load) begin
        shown_d = data;
      end else if (pend_v_q) begin
        shown_d = pend_q;
      end
    end
  end

  always_comb begin
    nibble      = '0;
    digit_sel_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble         = shown_q[4*i +: 4];
        digit_sel_d[i] = 1'b1;
      end
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (nibble),
    .seg_o    (seg_hex)
  );

`ifdef PDA_DISP_BLANK_EN
  logic blank;

  // Digit i is a leading zero when every nibble from i upwards is zero.
  always_comb begin
    blank = 1'b0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if ((idx_q == IW'(i)) && ((shown_q >> (4*i)) == '0)) begin
        blank = 1'b1;
      end
    end
    seg_d = blank ? SEG_BLANK : seg_hex;
  end
`else
  always_comb begin
    seg_d = seg_hex;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q      <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      shown_q     <= '0;
      frame_q     <= 1'b0;
      seg_q       <= SEG_BLANK;
      digit_sel_q <= '0;
    end else begin
      pcnt_q      <= pcnt_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      shown_q     <= shown_d;
      frame_q     <= frame_d;
      seg_q       <= seg_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign seg       = seg_q;
  assign digit_sel = digit_sel_q;
  assign shown     = shown_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_pixel_display_scanner.sv
// Scoreboard bench for pixel_display_scanner (DATA_W=32, DIGITS=4, SCAN_DIV=4).
module tb_pixel_display_scanner;

  localparam int SD = 4;
  localparam int DG = 4;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] data;
  logic        hold;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic [31:0] shown;
  logic        frame;

  int tests;
  int fails;

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  dsel;
    logic [31:0] shown;
    logic        frame;
  } exp_t;

  exp_t expq[$];

  // Reference state: t counts un-held cycles since reset.
  int          t;
  logic [31:0] shown_m;
  logic [31:0] pend_m;
  logic        pend_v_m;

  pixel_display_scanner #(
    .DATA_W   (32),
    .DIGITS   (4),
    .SCAN_DIV (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data      (data),
    .hold      (hold),
    .seg       (seg),
    .digit_sel (digit_sel),
    .shown     (shown),
    .frame     (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1111110;  4'h1: glyph = 7'b0110000;
      4'h2: glyph = 7'b1101101;  4'h3: glyph = 7'b1111001;
      4'h4: glyph = 7'b0110011;  4'h5: glyph = 7'b1011011;
      4'h6: glyph = 7'b1011111;  4'h7: glyph = 7'b1110000;
      4'h8: glyph = 7'b1111111;  4'h9: glyph = 7'b1111011;
      4'hA: glyph = 7'b1110111;  4'hB: glyph = 7'b0011111;
      4'hC: glyph = 7'b1001110;  4'hD: glyph = 7'b0111101;
      4'hE: glyph = 7'b1001111;  default: glyph = 7'b1000111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] w, input int d);
    logic [31:0] upper;
    upper = w >> (4 * d);
`ifdef PDA_DISP_BLANK_EN
    if (d != 0 && upper == 32'd0) return 7'b0000000;
`endif
    return glyph(upper[3:0]);
  endfunction

  always @(posedge clk or negedge reset) begin
    exp_t e;
    int   d;
    logic bnd;
    if (!reset) begin
      t        = 0;
      shown_m  = '0;
      pend_m   = '0;
      pend_v_m = 1'b0;
      expq.delete();
      e.seg = '0; e.dsel = '0; e.shown = '0; e.frame = 1'b0;
      expq.push_back(e);
    end else begin
      d   = (t / SD) % DG;
      bnd = !hold && (t % SD == SD - 1) && (d == DG - 1);
      e.dsel  = 4'(1 << d);
      e.seg   = exp_seg(shown_m, d);
      e.frame = bnd;
      if (bnd) begin
        if (load) shown_m = data;
        else if (pend_v_m) shown_m = pend_m;
        pend_v_m = 1'b0;
        if (load) pend_m = data;
      end else if (load) begin
        pend_m   = data;
        pend_v_m = 1'b1;
      end
      e.shown = shown_m;
      expq.push_back(e);
      if (!hold) t++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("seg",       32'(seg),       32'(e.seg));
      chk("digit_sel", 32'(digit_sel), 32'(e.dsel));
      chk("shown",     shown,          e.shown);
      chk("frame",     32'(frame),     32'(e.frame));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    load = 1'b1;
    data = v;
    step();
    load = 1'b0;
  endtask

  task automatic wait_phase(input int modulus, input int want, input int div);
    int guard;
    guard = 0;
    while (((t / div) % modulus) != want && guard < 64) begin
      step();
      guard++;
    end
    if (guard >= 64) begin
      fails++;
      tests++;
      $display("FAIL wait_phase timeout: got t=%0d, expected phase %0d", t, want);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    load  = 1'b0;
    data  = '0;
    hold  = 1'b0;
    step(3);
    reset = 1'b1;
    step(40);

    step(6);
    do_load(32'h0000_A3F5);
    step(40);

    wait_phase(16, 2, 1);
    do_load(32'h0000_1111);
    step(3);
    do_load(32'h0000_2222);
    step(36);

    do_load(32'h0000_0005);
    wait_phase(16, 15, 1);
    do_load(32'h0000_0007);
    step(36);

    wait_phase(DG, 2, SD);
    step(1);
    hold = 1'b1;
    step(20);
    hold = 1'b0;
    step(24);

    do_load(32'h0000_0030);
    step(40);

    step(7);
    do_load(32'hDEAD_BEEF);
    step(5);
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(40);

    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 7) == 0);
      data = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
      hold = ($urandom_range(0, 9) == 0);
      step();
    end
    load = 1'b0;
    hold = 1'b0;
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
